// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencing controller for the MIPS datapath.
// Optional macro MC_CTRL_PERF_EN adds free-running cycle_cnt and instr_cnt outputs.
module mc_ctrl #(
    parameter int FETCH_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    output logic [2:0]  state,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        dm_we,
    output logic [1:0]  npc_op,
    output logic [1:0]  alu_op,
    output logic        ext_op,
    output logic        alub_sel,
    output logic [1:0]  rfa3_sel,
    output logic [1:0]  rfwd_sel,
    output logic        instr_done
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
    } cls_t;

    state_t     st;
    cls_t       cls_q;
    cls_t       cls_dec;
    cls_t       cls;
    logic [3:0] wcnt;
    logic       fetch_last;

    assign fetch_last = (wcnt == 4'(FETCH_WAIT));
    // DECODE acts on the live IR fields; later states use the latched class
    assign cls = (st == S_DECODE) ? cls_dec : cls_q;

    always_comb begin
        cls_dec = C_NOP;
        case (opcode)
            6'b000000: begin
                case (func)
                    6'b100001: cls_dec = C_ADDU;
                    6'b100011: cls_dec = C_SUBU;
                    6'b001000: cls_dec = C_JR;
                    default:   cls_dec = C_NOP;
                endcase
            end
            6'b001101: cls_dec = C_ORI;
            6'b001111: cls_dec = C_LUI;
            6'b100011: cls_dec = C_LW;
            6'b101011: cls_dec = C_SW;
            6'b000100: cls_dec = C_BEQ;
            6'b000010: cls_dec = C_J;
            6'b000011: cls_dec = C_JAL;
            default:   cls_dec = C_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= S_FETCH;
            wcnt  <= '0;
            cls_q <= C_NOP;
        end else begin
            wcnt <= '0;
            case (st)
                S_FETCH: begin
                    if (fetch_last) st <= S_DECODE;
                    else            wcnt <= wcnt + 4'd1;
                end
                S_DECODE: begin
                    cls_q <= cls_dec;
                    case (cls_dec)
                        C_J, C_JAL, C_JR, C_NOP: st <= S_FETCH;
                        default:                 st <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LW, C_SW:                    st <= S_MEM;
                        C_ADDU, C_SUBU, C_ORI, C_LUI:  st <= S_WB;
                        default:                       st <= S_FETCH;
                    endcase
                end
                S_MEM:   st <= (cls_q == C_LW) ? S_WB : S_FETCH;
                default: st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        dm_we      = 1'b0;
        npc_op     = 2'd0;
        alu_op     = 2'd0;
        ext_op     = 1'b0;
        alub_sel   = 1'b0;
        rfa3_sel   = 2'd0;
        rfwd_sel   = 2'd0;
        instr_done = 1'b0;
        case (st)
            S_FETCH: begin
                ir_we = fetch_last;
                pc_we = fetch_last;
            end
            S_DECODE: begin
                case (cls)
                    C_J: begin
                        pc_we = 1'b1; npc_op = 2'd2; instr_done = 1'b1;
                    end
                    C_JAL: begin
                        pc_we = 1'b1; npc_op = 2'd2; instr_done = 1'b1;
                        rf_we = 1'b1; rfa3_sel = 2'd2; rfwd_sel = 2'd2;
                    end
                    C_JR: begin
                        pc_we = 1'b1; npc_op = 2'd3; instr_done = 1'b1;
                    end
                    C_NOP:   instr_done = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_SUBU: alu_op = 2'd1;
                    C_ORI: begin
                        alu_op = 2'd2; alub_sel = 1'b1;
                    end
                    C_LUI: begin
                        alu_op = 2'd3; alub_sel = 1'b1;
                    end
                    C_LW, C_SW: begin
                        alub_sel = 1'b1; ext_op = 1'b1;
                    end
                    C_BEQ: begin
                        alu_op = 2'd1; ext_op = 1'b1; npc_op = 2'd1;
                        pc_we = zero; instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dm_we      = (cls == C_SW);
                instr_done = (cls == C_SW);
            end
            S_WB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
                rfa3_sel   = (cls == C_ADDU || cls == C_SUBU) ? 2'd0 : 2'd1;
                rfwd_sel   = (cls == C_LW) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        // State is already FETCH under reset, but FETCH itself may assert writes
        if (reset) begin
            pc_we = 1'b0; ir_we = 1'b0; rf_we = 1'b0; dm_we = 1'b0;
            npc_op = 2'd0; alu_op = 2'd0; ext_op = 1'b0; alub_sel = 1'b0;
            rfa3_sel = 2'd0; rfwd_sel = 2'd0; instr_done = 1'b0;
        end
    end

    assign state = st;

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed vector table, random instruction stream vs. a cycle-index model.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       dm_we;
        logic [1:0] npc_op;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       alub_sel;
        logic [1:0] rfa3_sel;
        logic [1:0] rfwd_sel;
        logic       instr_done;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          len;
        logic [23:0] states;
    } vec_t;

    localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LUI = 5,
                   K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op0 = '0, fn0 = '0, op3 = '0, fn3 = '0;
    logic       z0 = 1'b0, z3 = 1'b0;
    wire outs_t o0;
    wire outs_t o3;
    int nchk = 0;
    int nfail = 0;

`ifdef MC_CTRL_PERF_EN
    wire [31:0] cyc0, ic0, cyc3, ic3;
`endif

    always #5 clk = ~clk;

    mc_ctrl #(.FETCH_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(op0), .func(fn0), .zero(z0),
        .state(o0.state), .pc_we(o0.pc_we), .ir_we(o0.ir_we), .rf_we(o0.rf_we),
        .dm_we(o0.dm_we), .npc_op(o0.npc_op), .alu_op(o0.alu_op), .ext_op(o0.ext_op),
        .alub_sel(o0.alub_sel), .rfa3_sel(o0.rfa3_sel), .rfwd_sel(o0.rfwd_sel),
        .instr_done(o0.instr_done)
`ifdef MC_CTRL_PERF_EN
        , .cycle_cnt(cyc0), .instr_cnt(ic0)
`endif
    );

    mc_ctrl #(.FETCH_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .opcode(op3), .func(fn3), .zero(z3),
        .state(o3.state), .pc_we(o3.pc_we), .ir_we(o3.ir_we), .rf_we(o3.rf_we),
        .dm_we(o3.dm_we), .npc_op(o3.npc_op), .alu_op(o3.alu_op), .ext_op(o3.ext_op),
        .alub_sel(o3.alub_sel), .rfa3_sel(o3.rfa3_sel), .rfwd_sel(o3.rfwd_sel),
        .instr_done(o3.instr_done)
`ifdef MC_CTRL_PERF_EN
        , .cycle_cnt(cyc3), .instr_cnt(ic3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                                (fn == 6'h08) ? K_JR : K_NOP;
        case (op)
            6'h0d: return K_ORI;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int inst_len(input int fw, input int c);
        if (c == K_J || c == K_JAL || c == K_JR || c == K_NOP) return fw + 2;
        if (c == K_BEQ) return fw + 3;
        if (c == K_LW) return fw + 5;
        return fw + 4;
    endfunction

    // Expected outputs in cycle k of an instruction, counting from its first FETCH cycle
    function automatic outs_t model(input int fw, input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input int k);
        outs_t e = '0;
        int c = cls_of(op, fn);
        int p = k - fw - 1;
        bit mem = (c == K_LW || c == K_SW);
        if (k <= fw) begin
            e.state = 3'd0;
            e.ir_we = (k == fw);
            e.pc_we = (k == fw);
        end else if (p == 0) begin
            e.state = 3'd1;
            e.instr_done = (c == K_J || c == K_JAL || c == K_JR || c == K_NOP);
            if (c == K_J || c == K_JAL) begin e.pc_we = 1; e.npc_op = 2; end
            if (c == K_JR) begin e.pc_we = 1; e.npc_op = 3; end
            if (c == K_JAL) begin e.rf_we = 1; e.rfa3_sel = 2; e.rfwd_sel = 2; end
        end else if (p == 1) begin
            e.state = 3'd2;
            case (c)
                K_SUBU: e.alu_op = 1;
                K_ORI: begin e.alu_op = 2; e.alub_sel = 1; end
                K_LUI: begin e.alu_op = 3; e.alub_sel = 1; end
                K_LW, K_SW: begin e.alub_sel = 1; e.ext_op = 1; end
                K_BEQ: begin
                    e.alu_op = 1; e.ext_op = 1; e.npc_op = 1; e.pc_we = z; e.instr_done = 1;
                end
                default: ;
            endcase
        end else if (p == 2 && mem) begin
            e.state = 3'd3;
            e.dm_we = (c == K_SW);
            e.instr_done = (c == K_SW);
        end else if ((p == 2 && !mem) || (p == 3 && c == K_LW)) begin
            e.state = 3'd4;
            e.rf_we = 1;
            e.instr_done = 1;
            e.rfa3_sel = (c == K_ADDU || c == K_SUBU) ? 2'd0 : 2'd1;
            e.rfwd_sel = (c == K_LW) ? 2'd1 : 2'd0;
        end
        return e;
    endfunction

    task automatic set_in(input int d, input logic [5:0] op, input logic [5:0] fn, input logic z);
        if (d == 3) begin op3 = op; fn3 = fn; z3 = z; end
        else begin op0 = op; fn0 = fn; z0 = z; end
    endtask

    // Called at posedge+1 with the DUT in its first FETCH cycle; returns at posedge+1 after done
    task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int exp_len, input logic [23:0] exp_st,
                             input bit chk_st, output int cycles);
        int fw = (d == 3) ? 3 : 0;
        int k = 0;
        bit done = 0;
        outs_t a;
        while (!done && k < 40) begin
            if (k <= fw) set_in(d, 6'($urandom), 6'($urandom), 1'($urandom));
            else         set_in(d, op, fn, z);
            #1;
            a = (d == 3) ? o3 : o0;
            chk($sformatf("outs op=%0h fn=%0h cyc%0d", op, fn, k), 32'(a), 32'(model(fw, op, fn, z, k)));
            if (chk_st && k < 8) chk($sformatf("state op=%0h cyc%0d", op, k), 32'(a.state), 32'(exp_st[3*k +: 3]));
            done = a.instr_done;
            k++;
            @(posedge clk);
            #1;
        end
        chk($sformatf("cycles op=%0h fn=%0h", op, fn), 32'(k), 32'(exp_len));
        cycles = k;
    endtask

    task automatic rand_instr(input int d, output int cycles);
        logic [5:0] iops [7] = '{6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
        logic [5:0] rfns [4] = '{6'h21, 6'h23, 6'h08, 6'h00};
        logic [5:0] op, fn;
        logic z = 1'($urandom);
        case ($urandom_range(0, 3))
            0: begin op = 6'($urandom); fn = 6'($urandom); end
            1: begin op = 6'h00; fn = rfns[$urandom_range(0, 3)]; if (fn == 6'h00) fn = 6'($urandom); end
            default: begin op = iops[$urandom_range(0, 6)]; fn = 6'($urandom); end
        endcase
        run_instr(d, op, fn, z, inst_len((d == 3) ? 3 : 0, cls_of(op, fn)), '0, 1'b0, cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [12];
        int cyc, total;
        vt[0]  = '{6'h00, 6'h21, 1'b0, 4, 24'o4210};   // addu $3,$1,$2
        vt[1]  = '{6'h23, 6'h00, 1'b0, 5, 24'o43210};  // lw $5,8($0)
        vt[2]  = '{6'h2b, 6'h00, 1'b0, 4, 24'o3210};   // sw $5,12($0)
        vt[3]  = '{6'h04, 6'h00, 1'b1, 3, 24'o210};    // beq taken
        vt[4]  = '{6'h04, 6'h00, 1'b0, 3, 24'o210};    // beq not taken
        vt[5]  = '{6'h03, 6'h00, 1'b0, 2, 24'o10};     // jal 0x0C00
        vt[6]  = '{6'h00, 6'h08, 1'b0, 2, 24'o10};     // jr $31
        vt[7]  = '{6'h00, 6'h23, 1'b0, 4, 24'o4210};   // subu
        vt[8]  = '{6'h0d, 6'h00, 1'b0, 4, 24'o4210};   // ori
        vt[9]  = '{6'h0f, 6'h00, 1'b0, 4, 24'o4210};   // lui
        vt[10] = '{6'h02, 6'h00, 1'b0, 2, 24'o10};     // j
        vt[11] = '{6'h3f, 6'h00, 1'b0, 2, 24'o10};     // NOP class

        repeat (2) @(posedge clk);
        #1;
        chk("reset outs dut0", 32'(o0), 32'h0);
        chk("reset outs dut3", 32'(o3), 32'h0);
`ifdef MC_CTRL_PERF_EN
        chk("reset cycle_cnt", cyc0, 32'h0);
        chk("reset instr_cnt", ic0, 32'h0);
`endif
        reset = 1'b0;
        foreach (vt[i]) run_instr(0, vt[i].op, vt[i].fn, vt[i].z, vt[i].len, vt[i].states, 1'b1, cyc);
        for (int i = 0; i < 60; i++) rand_instr(0, cyc);

        // Slow-IM variant: NOP with three extra FETCH cycles, then a random stream
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(3, 6'h3f, 6'h00, 1'b0, 5, 24'o10000, 1'b1, cyc);
        for (int i = 0; i < 20; i++) rand_instr(3, cyc);

        // Asynchronous reset landing in the MEM cycle of sw
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(0, 6'h2b, 6'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("sw MEM state", 32'(o0.state), 32'd3);
        chk("sw MEM dm_we", 32'(o0.dm_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset dm_we", 32'(o0.dm_we), 32'd0);
        chk("async reset state", 32'(o0.state), 32'd0);
        chk("async reset outs", 32'(o0), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef MC_CTRL_PERF_EN
        chk("post-reset cycle_cnt", cyc0, 32'h0);
        chk("post-reset instr_cnt", ic0, 32'h0);
`endif
        total = 0;
        for (int i = 0; i < 5; i++) begin
            rand_instr(0, cyc);
            total += cyc;
        end
`ifdef MC_CTRL_PERF_EN
        chk("perf cycle_cnt", cyc0, 32'(total));
        chk("perf instr_cnt", ic0, 32'd5);
`endif
        chk("final state", 32'(o0.state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
